// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and types for the parameterised FIFO.
//   ptr_w(depth)  - pointer width, at least 1 bit even for tiny depths.
//   cnt_w(depth)  - occupancy width, wide enough to hold the value depth.
//   fifo_status_t - flattened status bundle for CSR readout. Counts are
//                   fixed at STATUS_CNT_W bits so one CSR layout fits any
//                   FIFO depth; zero-extend count/high_water into it.
package fifo_pkg;

  localparam int STATUS_CNT_W = 16;

  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic [STATUS_CNT_W-1:0] count;
    logic                    almost_full;
    logic                    almost_empty;
    logic                    overflow;
    logic                    underflow;
    logic [STATUS_CNT_W-1:0] high_water;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: modulo-DEPTH pointer for the FIFO storage array.
//   clk  - clock, rising edge
//   rst  - async active-high reset, ptr -> 0
//   clr  - synchronous clear, wins over inc
//   inc  - advance by one, wrapping DEPTH-1 -> 0
//   ptr  - current pointer value
// The wrap is an explicit compare so non-power-of-2 depths work; the
// pointer never takes values DEPTH..2**PTR_W-1.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
  end

endmodule

// File: rtl/fifo_param.sv
// fifo_param: single-clock show-ahead FIFO, any DEPTH >= 2.
//   clk, rst      - clock (rising edge) and async active-high reset
//   flush         - synchronous clear of contents, errors and high-water
//   wr_en/wr_data - write request and data; accepted when wr_ready
//   wr_ready      - not full
//   rd_en         - pop request; accepted when rd_valid
//   rd_data       - head entry, combinational from storage (0 latency)
//   rd_valid      - not empty
//   count         - registered occupancy
//   almost_full   - count >= AF_TH
//   almost_empty  - count <= AE_TH
//   overflow      - sticky, write seen while full
//   underflow     - sticky, read seen while empty
//   high_water    - peak occupancy since reset/flush
// Full/empty come from the registered count, so a pop never frees space
// for a push in the same cycle (no pass-through) and a push is never
// visible to a pop in the same cycle.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_TH      = DEPTH - 1,
  parameter int AE_TH      = 1,
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [CNT_W-1:0]      high_water
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Parameter legality, caught at elaboration
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_param: DEPTH=%0d, must be >= 2", DEPTH);
  end
  if (AF_TH < 1 || AF_TH > DEPTH) begin : g_bad_af
    $error("fifo_param: AF_TH=%0d outside 1..DEPTH", AF_TH);
  end
  if (AE_TH < 0 || AE_TH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_param: AE_TH=%0d outside 0..DEPTH-1", AE_TH);
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_next;
  logic                  push, pop;

  // Status decode from the registered count
  assign wr_ready     = (count != FULL_CNT);
  assign rd_valid     = (count != '0);
  assign almost_full  = (count >= CNT_W'(AF_TH));
  assign almost_empty = (count <= CNT_W'(AE_TH));

  // flush swallows any transfer requested in the same cycle
  assign push = wr_en & wr_ready & ~flush;
  assign pop  = rd_en & rd_valid & ~flush;

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Storage has no reset; rd_valid qualifies rd_data
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      high_water <= '0;
    end else if (flush) begin
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      high_water <= '0;
    end else begin
      count <= count_next;
      if (wr_en && !wr_ready) overflow  <= 1'b1;
      if (rd_en && !rd_valid) underflow <= 1'b1;
      if (count_next > high_water) high_water <= count_next;
    end
  end

  // Occupancy implied by the pointers; full and empty both give 0,
  // so full is told apart by count itself.
  logic [CNT_W-1:0] ptr_diff;
  always_comb begin
    ptr_diff = '0;
    if (wr_ptr >= rd_ptr) ptr_diff = CNT_W'(wr_ptr) - CNT_W'(rd_ptr);
    else                  ptr_diff = CNT_W'(wr_ptr) + FULL_CNT - CNT_W'(rd_ptr);
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && count == FULL_CNT));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && count == '0));
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= FULL_CNT);
  a_count_ptrs: assert property (@(posedge clk) disable iff (rst)
    (count == FULL_CNT) ? (ptr_diff == '0) : (ptr_diff == count));

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed + short random bench for fifo_param at DEPTH=5.
// A reference model (queue + counters) tracks acceptance and flags; popped
// data is compared against the queue head.
module tb_fifo_param;

  localparam int DW = 8;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [2:0]    count;
  logic          almost_full, almost_empty, overflow, underflow;
  logic [2:0]    high_water;

  fifo_param #(.DATA_WIDTH(DW), .DEPTH(D), .AF_TH(AF), .AE_TH(AE)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .high_water   (high_water)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model
  logic [DW-1:0] q[$];
  int  m_cnt = 0;
  int  m_hw  = 0;
  bit  m_ov  = 0;
  bit  m_un  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_cnt = 0; m_hw = 0; m_ov = 0; m_un = 0;
  endtask

  task automatic check_status();
    check("count",        32'(count),        32'(m_cnt));
    check("wr_ready",     32'(wr_ready),     32'(m_cnt != D));
    check("rd_valid",     32'(rd_valid),     32'(m_cnt != 0));
    check("almost_full",  32'(almost_full),  32'(m_cnt >= AF));
    check("almost_empty", 32'(almost_empty), 32'(m_cnt <= AE));
    check("overflow",     32'(overflow),     32'(m_ov));
    check("underflow",    32'(underflow),    32'(m_un));
    check("high_water",   32'(high_water),   32'(m_hw));
  endtask

  // Called at posedge+1: drive, check head before the edge, advance the
  // model, clock, then check registered status at posedge+1.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit fl);
    bit acc_w, acc_r;
    wr_en = we; wr_data = wd; rd_en = re; flush = fl;
    #1;
    acc_w = we && (m_cnt != D) && !fl;
    acc_r = re && (m_cnt != 0) && !fl;
    if (acc_r) check("rd_data", 32'(rd_data), 32'(q[0]));
    if (fl) begin
      model_clear();
    end else begin
      if (we && m_cnt == D) m_ov = 1;
      if (re && m_cnt == 0) m_un = 1;
      if (acc_r) void'(q.pop_front());
      if (acc_w) q.push_back(wd);
      m_cnt = q.size();
      if (m_cnt > m_hw) m_hw = m_cnt;
    end
    @(posedge clk);
    #1;
    wr_en = 0; rd_en = 0; flush = 0;
    check_status();
  endtask

  task automatic idle(); step(0, '0, 0, 0); endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    check_status();

    // fill to full, then one write too many
    for (int i = 0; i < 5; i++) step(1, 8'h11 + 8'(i), 0, 0);
    step(1, 8'h16, 0, 0);
    check("hw_after_fill", 32'(high_water), 32'd5);
    check("ov_after_fill", 32'(overflow), 32'd1);

    // drain in order, then one read too many
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    check("un_after_drain", 32'(underflow), 32'd1);

    // wrap: push 3 / pop 3 for 4 rounds
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + r * 4 + i), 0, 0);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
    end
    check("wrap_count", 32'(count), 32'd0);
    step(1, 8'h51, 0, 0);
    step(1, 8'h52, 0, 0);
    step(1, 8'h53, 1, 0);
    check("simul_cnt2", 32'(count), 32'd2);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // full with both requests: pop wins, push rejected
    for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 0);
    step(1, 8'h6f, 1, 0);
    check("full_both_cnt", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    // empty with both requests: push wins, pop rejected
    step(1, 8'h77, 1, 0);
    check("empty_both_cnt", 32'(count), 32'd1);
    step(0, '0, 1, 0);

    // flush at count 3 together with a write
    for (int i = 0; i < 3; i++) step(1, 8'h80 + 8'(i), 0, 0);
    step(1, 8'h8f, 0, 1);
    check("flush_cnt", 32'(count), 32'd0);
    check("flush_hw", 32'(high_water), 32'd0);
    step(1, 8'h90, 0, 0);
    idle();

    // short random phase against the model
    for (int i = 0; i < 80; i++)
      step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0));

    // async reset mid-burst, checked before any clock edge
    step(1, 8'ha1, 0, 0);
    step(1, 8'ha2, 0, 0);
    wr_en = 1; wr_data = 8'ha3;
    #2 rst = 1'b1;
    #1;
    model_clear();
    check("async_count", 32'(count), 32'd0);
    check("async_rd_valid", 32'(rd_valid), 32'd0);
    check("async_wr_ready", 32'(wr_ready), 32'd1);
    check("async_hw", 32'(high_water), 32'd0);
    check("async_ov", 32'(overflow), 32'd0);
    check("async_un", 32'(underflow), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; wr_en = 0;
    check_status();
    step(1, 8'hb1, 0, 0);
    step(0, '0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
